// File: rtl/btn_debounce.sv
// Push-button conditioner: per-channel synchroniser plus a two-state debounce FSM.
// Produces a debounced level, one-cycle rise/fall pulses and a press-toggled level.
module btn_debounce #(
  parameter int NUM_BTN         = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic               clkin,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_rise,
  output logic [NUM_BTN-1:0] btn_fall,
  output logic [NUM_BTN-1:0] btn_toggle
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] sync_q [SYNC_STAGES];
  logic [NUM_BTN-1:0] s;
  state_e             state_q [NUM_BTN];
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [NUM_BTN-1:0] level_q;
  logic [NUM_BTN-1:0] rise_q;
  logic [NUM_BTN-1:0] fall_q;
  logic [NUM_BTN-1:0] toggle_q;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= btn_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // The committed level doubles as the FSM's reference value; a change is only
  // accepted once the synchronised input has disagreed with it for the full count.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      level_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      toggle_q <= '0;
    end else begin
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        case (state_q[i])
          IDLE: begin
            if (s[i] != level_q[i]) begin
              state_q[i] <= WAIT;
              cnt_q[i]   <= CNT_W'(1);
            end else begin
              cnt_q[i] <= '0;
            end
          end
          WAIT: begin
            if (s[i] == level_q[i]) begin
              state_q[i] <= IDLE;
              cnt_q[i]   <= '0;
            end else if (cnt_q[i] == CNT_LAST) begin
              level_q[i] <= s[i];
              if (s[i]) begin
                rise_q[i]   <= 1'b1;
                toggle_q[i] <= ~toggle_q[i];
              end else begin
                fall_q[i] <= 1'b1;
              end
              state_q[i] <= IDLE;
              cnt_q[i]   <= '0;
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
          end
          default: begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
          end
        endcase
      end
    end
  end

  assign btn_level  = level_q;
  assign btn_rise   = rise_q;
  assign btn_fall   = fall_q;
  assign btn_toggle = toggle_q;

endmodule
